// File: rtl/p_frame_fifo_if.sv
// Handshake bundle between the UART receiver/sender pair and p_frame_fifo.
// The FIFO takes the slave side; the surrounding logic (or a bench) takes the master side.
interface p_frame_fifo_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 3
);
    logic              recv_done;
    logic [DATA_W-1:0] recv_data;
    logic              tx_busy;
    logic              send_en;
    logic [DATA_W-1:0] send_data;
    logic [ADDR_W:0]   fifo_level;
    logic [7:0]        ovf_cnt;
    logic [7:0]        drop_cnt;

    modport slave (
        input  recv_done, recv_data, tx_busy,
        output send_en, send_data, fifo_level, ovf_cnt, drop_cnt
    );

    modport master (
        output recv_done, recv_data, tx_busy,
        input  send_en, send_data, fifo_level, ovf_cnt, drop_cnt
    );
endinterface

// File: rtl/p_frame_fifo.sv
// Frame FIFO between p_uart_recv and p_uart_send: queues frames and relaunches them when TX is idle.
// Optional checksum filter on byte 7 is enabled by defining P_FRAME_CHK_EN.
module p_frame_fifo #(
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 3,
    parameter int BUSY_TIMEOUT = 16
) (
    input logic           sys_clk,
    input logic           sys_rst,
    p_frame_fifo_if.slave bus
);
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int TIMER_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

    state_t             state;
    state_t             state_next;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [ADDR_W:0]    level;
    logic [TIMER_W-1:0] timer;
    logic               send_en_q;
    logic [DATA_W-1:0]  send_data_q;
    logic [7:0]         ovf_q;
    logic               pop;
    logic               timer_done;
    logic               full;
    logic               frame_ok;
    logic               wr_accept;
    logic               ovf_inc;

    assign full       = (level == (ADDR_W+1)'(DEPTH));
    assign timer_done = (timer == TIMER_W'(BUSY_TIMEOUT - 1));

`ifdef P_FRAME_CHK_EN
    logic [7:0] chk_calc;
    logic [7:0] drop_q;
    logic       drop_inc;

    // Top byte must equal the XOR of all payload bytes below it
    always_comb begin
        chk_calc = 8'd0;
        for (int i = 0; i < DATA_W/8 - 1; i++) begin
            chk_calc = chk_calc ^ bus.recv_data[i*8 +: 8];
        end
    end

    assign frame_ok = (bus.recv_data[DATA_W-1 -: 8] == chk_calc);
    assign drop_inc = bus.recv_done && !frame_ok;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            drop_q <= 8'd0;
        end else if (drop_inc && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.drop_cnt = drop_q;
`else
    assign frame_ok     = 1'b1;
    assign bus.drop_cnt = 8'd0;
`endif

    // A full FIFO still accepts a frame when a pop frees the slot on the same edge
    assign wr_accept = bus.recv_done && frame_ok && (!full || pop);
    assign ovf_inc   = bus.recv_done && frame_ok && full && !pop;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pop) state_next = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.tx_busy)     state_next = WAIT_LO;
                else if (timer_done) state_next = IDLE;
            end
            WAIT_LO: begin
                if (!bus.tx_busy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop = 1'b0;
        if (state == IDLE && level != '0 && !bus.tx_busy) pop = 1'b1;
    end

    // Storage has no reset; validity is tracked by the pointers and level
    always_ff @(posedge sys_clk) begin
        if (wr_accept) mem[wr_ptr] <= bus.recv_data;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)       rd_ptr <= rd_ptr + 1'b1;
            case ({wr_accept, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            send_en_q   <= 1'b0;
            send_data_q <= '0;
        end else begin
            send_en_q <= pop;
            if (pop) send_data_q <= mem[rd_ptr];
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            timer <= '0;
        end else if (pop) begin
            timer <= '0;
        end else if (state == WAIT_HI && !bus.tx_busy && !timer_done) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ovf_q <= 8'd0;
        end else if (ovf_inc && ovf_q != 8'hFF) begin
            ovf_q <= ovf_q + 8'd1;
        end
    end

    assign bus.send_en    = send_en_q;
    assign bus.send_data  = send_data_q;
    assign bus.fifo_level = level;
    assign bus.ovf_cnt    = ovf_q;
endmodule

// File: tb/tb_p_frame_fifo.sv
// Directed bench for p_frame_fifo: scoreboard of queued frames, behavioural sender with tx_busy.
// Test 5 expectations follow P_FRAME_CHK_EN.
module tb_p_frame_fifo;
    localparam int DATA_W       = 64;
    localparam int ADDR_W       = 3;
    localparam int BUSY_TIMEOUT = 16;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    p_frame_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    p_frame_fifo #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus(bus)
    );

    always #10 sys_clk = ~sys_clk;

    int                checks = 0;
    int                errors = 0;
    logic [DATA_W-1:0] sb[$];
    logic              force_busy  = 1'b0;
    logic              sender_auto = 1'b1;
    logic              require_hs  = 1'b0;
    logic              prev_en     = 1'b0;
    logic              hs_hi       = 1'b0;
    logic              hs_done     = 1'b0;
    int                busy_left   = 0;
    int                busy_len    = 3;
    int                launches    = 0;

    assign bus.tx_busy = force_busy | (busy_left != 0);

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_frame(input logic [55:0] payload);
        logic [7:0] x;
        x = 8'd0;
        for (int i = 0; i < 7; i++) x = x ^ payload[i*8 +: 8];
        return {x, payload};
    endfunction

    // Called just after a falling edge; the frame is captured on the next rising edge
    task automatic apply_stimulus(input logic [63:0] frame, input bit stored);
        bus.recv_done = 1'b1;
        bus.recv_data = frame;
        if (stored) sb.push_back(frame);
        @(negedge sys_clk);
        bus.recv_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_drain(input string tag, input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) @(negedge sys_clk);
        check_output(tag, 64'(sb.size()), 64'd0);
    endtask

    // Output monitor plus sender model; one process so tx_busy updates never race the checks
    always @(negedge sys_clk) begin
        if (!sys_rst && bus.send_en) begin
            launches++;
            check_output("pulse_width", 64'(prev_en), 64'd0);
            check_output("unexpected_send", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) check_output("send_data", bus.send_data, sb.pop_front());
            if (require_hs) check_output("handshake", 64'(hs_done), 64'd1);
            hs_hi   = 1'b0;
            hs_done = 1'b0;
        end else if (bus.tx_busy) begin
            hs_hi = 1'b1;
        end else if (hs_hi) begin
            hs_done = 1'b1;
        end
        prev_en = bus.send_en;
        if (bus.send_en && sender_auto) busy_left = busy_len;
        else if (busy_left != 0) busy_left--;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gap;
        int snap;
        bus.recv_done = 1'b0;
        bus.recv_data = '0;

        $display("[TB] reset values");
        idle(3);
        check_output("rst_send_en",   64'(bus.send_en),    64'd0);
        check_output("rst_send_data", bus.send_data,       64'd0);
        check_output("rst_level",     64'(bus.fifo_level), 64'd0);
        check_output("rst_ovf",       64'(bus.ovf_cnt),    64'd0);
        check_output("rst_drop",      64'(bus.drop_cnt),   64'd0);
        sys_rst = 1'b0;
        idle(1);

        $display("[TB] test 1: single frame latency");
        apply_stimulus(64'h1122334455667700, 1'b1);
        check_output("t1_en_cycle1",    64'(bus.send_en),    64'd0);
        check_output("t1_level_cycle1", 64'(bus.fifo_level), 64'd1);
        idle(1);
        check_output("t1_en_cycle2",    64'(bus.send_en),    64'd1);
        check_output("t1_level_cycle2", 64'(bus.fifo_level), 64'd0);
        wait_drain("t1_drain", 50);
        idle(10);

        $display("[TB] test 2: overflow while sender busy");
        force_busy = 1'b1;
        for (int i = 0; i < 10; i++)
            apply_stimulus(mk_frame({8'h2A, 16'(i), 32'h0BADF00D ^ 32'(i * 7)}), i < 8);
        check_output("t2_level_full", 64'(bus.fifo_level), 64'd8);
        check_output("t2_ovf",        64'(bus.ovf_cnt),    64'd2);
        require_hs = 1'b1;
        force_busy = 1'b0;
        wait_drain("t2_drain", 300);
        idle(10);
        check_output("t2_level_empty", 64'(bus.fifo_level), 64'd0);

        $display("[TB] test 3: write and pop on one edge while full");
        force_busy = 1'b1;
        for (int i = 0; i < 8; i++)
            apply_stimulus(mk_frame({8'h3B, 16'(i), 32'h12345678 + 32'(i * 3)}), 1'b1);
        check_output("t3_level_full", 64'(bus.fifo_level), 64'd8);
        force_busy = 1'b0;
        apply_stimulus(mk_frame(56'h3C_00FF_CAFE_BEEF), 1'b1);
        check_output("t3_level_kept", 64'(bus.fifo_level), 64'd8);
        check_output("t3_ovf_kept",   64'(bus.ovf_cnt),    64'd2);
        check_output("t3_popped",     64'(bus.send_en),    64'd1);
        wait_drain("t3_drain", 300);
        require_hs = 1'b0;
        idle(10);

        $display("[TB] test 4: busy timeout");
        sender_auto = 1'b0;
        apply_stimulus(mk_frame(56'h44_0000_0000_0001), 1'b1);
        apply_stimulus(mk_frame(56'h44_0000_0000_0002), 1'b1);
        for (int i = 0; i < 20 && !bus.send_en; i++) @(negedge sys_clk);
        check_output("t4_first_launch", 64'(bus.send_en), 64'd1);
        gap = 0;
        do begin
            @(negedge sys_clk);
            gap++;
        end while (!bus.send_en && gap < 40);
        check_output("t4_gap", 64'(gap), 64'd17);
        wait_drain("t4_drain", 50);
        idle(30);
        sender_auto = 1'b1;

        $display("[TB] test 5: checksum");
`ifdef P_FRAME_CHK_EN
        apply_stimulus(mk_frame(56'h55_1234_5678_9ABC) ^ 64'h0100_0000_0000_0000, 1'b0);
        idle(1);
        check_output("t5_drop",  64'(bus.drop_cnt),   64'd1);
        check_output("t5_level", 64'(bus.fifo_level), 64'd0);
        idle(5);
`else
        apply_stimulus(mk_frame(56'h55_1234_5678_9ABC) ^ 64'h0100_0000_0000_0000, 1'b1);
        idle(1);
        check_output("t5_drop", 64'(bus.drop_cnt), 64'd0);
        wait_drain("t5_bad_sent", 50);
        idle(10);
`endif
        apply_stimulus(mk_frame(56'h56_0F0F_F0F0_AA55), 1'b1);
        wait_drain("t5_good_drain", 50);
        idle(10);

        $display("[TB] test 6: reset in WAIT_LO");
        busy_len = 10;
        snap = launches;
        for (int i = 0; i < 4; i++)
            apply_stimulus(mk_frame({8'h66, 16'(i), 32'hFACE0000 | 32'(i)}), 1'b1);
        idle(2);
        check_output("t6_level_pre",    64'(bus.fifo_level), 64'd3);
        check_output("t6_launches_pre", 64'(launches - snap), 64'd1);
        #2;
        sys_rst = 1'b1;
        #1;
        check_output("t6_send_en",   64'(bus.send_en),    64'd0);
        check_output("t6_send_data", bus.send_data,       64'd0);
        check_output("t6_level",     64'(bus.fifo_level), 64'd0);
        check_output("t6_ovf",       64'(bus.ovf_cnt),    64'd0);
        check_output("t6_drop",      64'(bus.drop_cnt),   64'd0);
        sb.delete();
        @(negedge sys_clk);
        sys_rst  = 1'b0;
        busy_len = 3;
        snap     = launches;
        idle(30);
        check_output("t6_no_launch", 64'(launches - snap), 64'd0);
        apply_stimulus(mk_frame(56'h67_0102_0304_0506), 1'b1);
        wait_drain("t6_new_drain", 50);
        idle(5);
        check_output("t6_level_end", 64'(bus.fifo_level), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
